mem_stage: RTL and testbench

Memory-access stage sitting directly downstream of the execute stage. Consumes the execute result (effective address or ALU/link value), store data and decoded opcode/funct3. Performs RV32I loads and stores against a single-port data memory over a req/ack handshake, and presents one write-back record per accepted instruction. Stalls upstream through `in_ready` while a memory transaction is outstanding.

---
 rtl/mem_stage.sv | 106 ++++++++++
 tb/tb_mem_stage.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: RV32I memory-access stage with req/ack data-memory handshake and one write-back record per instruction
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] result,
  input  logic [31:0] data,
  input  logic [4:0]  rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        access_fault
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_nx;
  logic [2:0] f3_q;
  logic [1:0] a_q;
  logic [4:0] rd_q;
  logic is_load, is_store, f3_ok, misalign, fault, mem_go, writes, accept, ack_w;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, shifted, ld_val;
  assign is_load  = opcode == 7'b0000011;
  assign is_store = opcode == 7'b0100011;
  assign f3_ok    = is_load ? (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) : (funct3 inside {3'b000, 3'b001, 3'b010});
  // funct3[1:0] encodes access size for both loads and stores: 01 half, 10 word
  assign misalign = funct3[1:0] == 2'b01 ? result[0] : funct3[1:0] == 2'b10 ? |result[1:0] : 1'b0;
  assign fault    = (is_load | is_store) & (!f3_ok | misalign);
  assign mem_go   = (is_load | is_store) & !fault;
  assign writes   = opcode inside {7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
  assign accept   = in_valid & in_ready;
  assign ack_w    = (state == WAIT) & dmem_ack;
  assign st_be    = funct3 == 3'b000 ? 4'b0001 << result[1:0] : funct3 == 3'b001 ? 4'b0011 << result[1:0] : 4'b1111;
  assign st_wdata = funct3 == 3'b000 ? {4{data[7:0]}} : funct3 == 3'b001 ? {2{data[15:0]}} : data;
  assign shifted  = dmem_rdata >> {a_q, 3'b000};
  assign ld_val   = f3_q == 3'b000 ? {{24{shifted[7]}}, shifted[7:0]} :
                    f3_q == 3'b001 ? {{16{shifted[15]}}, shifted[15:0]} :
                    f3_q == 3'b100 ? {24'b0, shifted[7:0]} :
                    f3_q == 3'b101 ? {16'b0, shifted[15:0]} : dmem_rdata;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // next state: leave IDLE only for a legal memory access, leave WAIT on ack
  always_comb
    state_nx = state == IDLE ? (accept && mem_go ? WAIT : IDLE) : (dmem_ack ? IDLE : WAIT);
  // the only combinational output
  always_comb
    in_ready = state == IDLE;
  // memory request and write-back record registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_be      <= '0;
      dmem_wdata   <= '0;
      wb_valid     <= 1'b0;
      wb_en        <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      access_fault <= 1'b0;
      f3_q         <= '0;
      a_q          <= '0;
      rd_q         <= '0;
    end else begin
      wb_valid     <= 1'b0;
      wb_en        <= 1'b0;
      access_fault <= 1'b0;
      if (accept && mem_go) begin
        dmem_req   <= 1'b1;
        dmem_we    <= is_store;
        dmem_addr  <= {result[31:2], 2'b00};
        dmem_be    <= is_store ? st_be : 4'b0000;
        dmem_wdata <= is_store ? st_wdata : 32'b0;
        f3_q       <= funct3;
        a_q        <= result[1:0];
        rd_q       <= rd;
      end else if (accept) begin
        wb_valid     <= 1'b1;
        wb_en        <= !fault && writes && rd != 5'd0;
        wb_rd        <= rd;
        wb_data      <= result;
        access_fault <= fault;
      end
      if (ack_w) begin
        dmem_req <= 1'b0;
        dmem_we  <= 1'b0;
        dmem_be  <= 4'b0000;
        wb_valid <= 1'b1;
        wb_en    <= !dmem_we && rd_q != 5'd0;
        wb_rd    <= rd_q;
        wb_data  <= dmem_we ? 32'b0 : ld_val;
      end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a behavioural model
module tb_mem_stage;
  logic        clk = 0, rst = 1, in_valid = 0, dmem_ack = 0;
  logic [6:0]  opcode = 0;
  logic [2:0]  funct3 = 0;
  logic [31:0] result = 0, data = 0, dmem_rdata = 0;
  logic [4:0]  rd = 0;
  logic        in_ready, dmem_req, dmem_we, wb_valid, wb_en, access_fault;
  logic [31:0] dmem_addr, dmem_wdata, wb_data;
  logic [3:0]  dmem_be;
  logic [4:0]  wb_rd;
  int total = 0, bad = 0;

  mem_stage dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
    .funct3(funct3), .result(result), .data(data), .rd(rd), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .wb_valid(wb_valid), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .access_fault(access_fault));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input [6:0] op, input [2:0] f3, input [31:0] res, input [31:0] dat, input [4:0] r);
    in_valid = 1; opcode = op; funct3 = f3; result = res; data = dat; rd = r;
  endtask

  // Behavioural model of one instruction's outcome, from the RV32I rules
  function automatic void model(input [6:0] op, input [2:0] f3, input [31:0] res, input [31:0] dat,
      input [4:0] r, input [31:0] rdata, output bit mem, output bit st, output bit en, output bit flt,
      output logic [31:0] wd, output logic [3:0] be, output logic [31:0] wdat);
    int size, off;
    longint v;
    bit ld = op == 7'h03, sto = op == 7'h23;
    size = 1 << f3[1:0];
    off = res % 4;
    flt = 0; mem = 0; st = sto; en = 0; wd = res; be = 0; wdat = 0;
    if (ld || sto) begin
      flt = (ld && !(f3 inside {0, 1, 2, 4, 5})) || (sto && f3 > 2) || (res % size != 0);
      mem = !flt;
      if (sto) begin
        be = (size == 4) ? 4'hF : 4'((size == 2 ? 3 : 1) << off);
        wdat = (size == 1) ? dat[7:0] * 32'h01010101 : (size == 2) ? dat[15:0] * 32'h00010001 : dat;
      end else begin
        v = (rdata >> (8 * off)) % (64'd1 << (8 * size));
        if (f3 < 4 && size < 4 && v >= (64'd1 << (8 * size - 1))) v = v - (64'd1 << (8 * size));
        wd = 32'(v);
        en = mem && r != 0;
      end
    end else
      en = (op inside {7'h33, 7'h13, 7'h37, 7'h17, 7'h6f, 7'h67}) && r != 0;
  endfunction

  task automatic test_reset();
    rst = 1;
    #2;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
    total++; if ({dmem_req, dmem_we, dmem_be, wb_valid, wb_en, access_fault} !== 9'b0) begin bad++; $display("FAIL reset_ctrl got=%0h exp=0", {dmem_req, dmem_we, dmem_be, wb_valid, wb_en, access_fault}); end
    total++; if ({dmem_addr, dmem_wdata, wb_rd, wb_data} !== 101'b0) begin bad++; $display("FAIL reset_data got=%0h exp=0", {dmem_addr, dmem_wdata, wb_rd, wb_data}); end
    tick();
    rst = 0;
    tick();
  endtask

  task automatic test_add();
    drive(7'b0110011, 3'b000, 32'h12345678, 32'h0, 5'd5);
    tick();
    in_valid = 0;
    total++; if ({wb_valid, wb_en, access_fault} !== 3'b110) begin bad++; $display("FAIL add_flags got=%b exp=110", {wb_valid, wb_en, access_fault}); end
    total++; if (wb_rd !== 5'd5) begin bad++; $display("FAIL add_rd got=%0d exp=5", wb_rd); end
    total++; if (wb_data !== 32'h12345678) begin bad++; $display("FAIL add_data got=%h exp=12345678", wb_data); end
    total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL add_req got=%0h exp=0", dmem_req); end
    tick();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL add_pulse got=%0h exp=0", wb_valid); end
  endtask

  task automatic test_load_byte(input [2:0] f3, input [31:0] exp);
    drive(7'b0000011, f3, 32'h1003, 32'h0, 5'd7);
    tick();
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      total++; if ({dmem_req, dmem_we, dmem_be, in_ready} !== 7'b1000000) begin bad++; $display("FAIL lb_req_%0d got=%b exp=1000000", i, {dmem_req, dmem_we, dmem_be, in_ready}); end
      total++; if (dmem_addr !== 32'h1000) begin bad++; $display("FAIL lb_addr_%0d got=%h exp=1000", i, dmem_addr); end
      tick();
    end
    dmem_ack = 1; dmem_rdata = 32'h80FF0000;
    tick();
    dmem_ack = 0; dmem_rdata = 32'hx;
    total++; if ({wb_valid, wb_en, access_fault, dmem_req} !== 4'b1100) begin bad++; $display("FAIL lb_wb_flags got=%b exp=1100", {wb_valid, wb_en, access_fault, dmem_req}); end
    total++; if (wb_data !== exp || wb_rd !== 5'd7) begin bad++; $display("FAIL lb_wb_data got=%h/%0d exp=%h/7", wb_data, wb_rd, exp); end
  endtask

  task automatic test_store_half();
    drive(7'b0100011, 3'b001, 32'h2002, 32'hAAAABEEF, 5'd0);
    tick();
    in_valid = 0;
    total++; if ({dmem_req, dmem_we, dmem_be} !== 6'b111100) begin bad++; $display("FAIL sh_ctrl got=%b exp=111100", {dmem_req, dmem_we, dmem_be}); end
    total++; if (dmem_wdata !== 32'hBEEFBEEF || dmem_addr !== 32'h2000) begin bad++; $display("FAIL sh_wdata got=%h@%h exp=beefbeef@2000", dmem_wdata, dmem_addr); end
    dmem_ack = 1;
    tick();
    dmem_ack = 0;
    total++; if ({wb_valid, wb_en, access_fault} !== 3'b100) begin bad++; $display("FAIL sh_wb got=%b exp=100", {wb_valid, wb_en, access_fault}); end
  endtask

  task automatic test_fault();
    drive(7'b0000011, 3'b010, 32'h3001, 32'h0, 5'd9);
    tick();
    in_valid = 0;
    total++; if (dmem_req !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL lw_mis_req got=%b exp=01", {dmem_req, in_ready}); end
    total++; if ({wb_valid, wb_en, access_fault} !== 3'b101) begin bad++; $display("FAIL lw_mis_wb got=%b exp=101", {wb_valid, wb_en, access_fault}); end
  endtask

  task automatic test_back_to_back();
    drive(7'b0000011, 3'b010, 32'h400, 32'h0, 5'd3);
    tick();
    dmem_ack = 1; dmem_rdata = 32'hCAFEF00D;
    drive(7'b0010011, 3'b000, 32'h55, 32'h0, 5'd4);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_busy got=%0h exp=0", in_ready); end
    tick();
    dmem_ack = 0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_len got=%0h exp=1", in_ready); end
    total++; if (wb_valid !== 1'b1 || wb_data !== 32'hCAFEF00D || wb_rd !== 5'd3) begin bad++; $display("FAIL stall_load_wb got=%0h/%h/%0d exp=1/cafef00d/3", wb_valid, wb_data, wb_rd); end
    tick();
    in_valid = 0;
    total++; if (wb_valid !== 1'b1 || wb_data !== 32'h55 || wb_rd !== 5'd4 || wb_en !== 1'b1) begin bad++; $display("FAIL stall_addi_wb got=%0h/%h/%0d exp=1/55/4", wb_valid, wb_data, wb_rd); end
  endtask

  task automatic test_reset_wait();
    drive(7'b0000011, 3'b000, 32'h500, 32'h0, 5'd6);
    tick();
    in_valid = 0;
    total++; if (dmem_req !== 1'b1) begin bad++; $display("FAIL rstw_req got=%0h exp=1", dmem_req); end
    rst = 1;
    #1;
    total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL rstw_async got=%0h exp=0", dmem_req); end
    tick();
    rst = 0;
    dmem_ack = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      dmem_ack = 0;
      total++; if (wb_valid !== 1'b0 || in_ready !== 1'b1 || dmem_req !== 1'b0) begin bad++; $display("FAIL rstw_after_%0d got=%b exp=010", i, {wb_valid, in_ready, dmem_req}); end
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [12] = '{7'h03, 7'h03, 7'h03, 7'h23, 7'h23, 7'h33, 7'h13, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h63};
    for (int n = 0; n < 60; n++) begin
      logic [6:0] op; logic [2:0] f3; logic [31:0] res, dat, rdata, wd, wdat; logic [4:0] r; logic [3:0] be;
      bit mem, st, en, flt;
      int waits;
      op = ops[$urandom_range(0, 11)];
      f3 = 3'($urandom);
      res = $urandom;
      if ($urandom_range(0, 1) == 1) res[1:0] = 2'b00;
      dat = $urandom;
      rdata = $urandom;
      r = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      waits = $urandom_range(0, 3);
      model(op, f3, res, dat, r, rdata, mem, st, en, flt, wd, be, wdat);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rnd%0d_ready got=%0h exp=1", n, in_ready); end
      drive(op, f3, res, dat, r);
      dmem_ack = 1'($urandom);
      tick();
      in_valid = 0; dmem_ack = 0;
      if (mem) begin
        total++; if ({dmem_req, dmem_we, dmem_be} !== {1'b1, st, be}) begin bad++; $display("FAIL rnd%0d_req got=%b exp=%b", n, {dmem_req, dmem_we, dmem_be}, {1'b1, st, be}); end
        total++; if (dmem_addr !== {res[31:2], 2'b00} || (st && dmem_wdata !== wdat)) begin bad++; $display("FAIL rnd%0d_addr got=%h/%h exp=%h/%h", n, dmem_addr, dmem_wdata, {res[31:2], 2'b00}, wdat); end
        for (int i = 0; i < waits; i++) begin
          tick();
          total++; if (in_ready !== 1'b0 || dmem_req !== 1'b1 || dmem_addr !== {res[31:2], 2'b00} || wb_valid !== 1'b0) begin bad++; $display("FAIL rnd%0d_hold got=%b/%h", n, {in_ready, dmem_req, wb_valid}, dmem_addr); end
        end
        dmem_ack = 1; dmem_rdata = rdata;
        tick();
        dmem_ack = 0;
        total++; if ({wb_valid, wb_en, access_fault, dmem_req} !== {1'b1, en, 1'b0, 1'b0}) begin bad++; $display("FAIL rnd%0d_mwb got=%b exp=%b", n, {wb_valid, wb_en, access_fault, dmem_req}, {1'b1, en, 2'b00}); end
        total++; if (wb_rd !== r || (!st && wb_data !== wd)) begin bad++; $display("FAIL rnd%0d_mdata got=%h/%0d exp=%h/%0d", n, wb_data, wb_rd, wd, r); end
      end else begin
        total++; if ({wb_valid, wb_en, access_fault, dmem_req} !== {1'b1, en, flt, 1'b0}) begin bad++; $display("FAIL rnd%0d_wb got=%b exp=%b", n, {wb_valid, wb_en, access_fault, dmem_req}, {1'b1, en, flt, 1'b0}); end
        if (!flt) begin
          total++; if (wb_data !== wd || wb_rd !== r) begin bad++; $display("FAIL rnd%0d_data got=%h/%0d exp=%h/%0d", n, wb_data, wb_rd, wd, r); end
        end
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_add();
    test_load_byte(3'b000, 32'hFFFFFF80);
    test_load_byte(3'b100, 32'h00000080);
    test_store_half();
    test_fault();
    test_back_to_back();
    test_reset_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
